mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter that shares a single unified memory port between the instruction-fetch path and the load/store data path of the MIPS core. It accepts the data-memory controls the decoder already produces (read/write enable, size, signed), performs byte-lane steering and load extension, and raises a stall so the PC holds while any access is outstanding.

## Interface
- `TIMEOUT`, default 255: wait-state limit per memory access; 0 disables the timeout.
- `clk_in`  input  1  clock, rising edge.
- `rst_n_in`  input  1  reset, asynchronous and active-low.
- `if_req_in`  input  1  fetch request; held until `if_ack_out`.
- `if_addr_in`  input  32  fetch address; bits [1:0] ignored.
- `if_ack_out`  output  1  one-cycle fetch completion.
- `if_rdata_out`  output  32  fetched word; valid with `if_ack_out`.
- `dm_re_in`  input  1  data read request.
- `dm_we_in`  input  1  data write request.
- `dm_size_in`  input  2  size: 11 word, 01 halfword, 00 byte, 10 treated as word.
- `dm_signed_in`  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
- `dm_addr_in`  input  32  data byte address.
- `dm_wdata_in`  input  32  store data, right-justified.
- `dm_ack_out`  output  1  one-cycle data completion.
- `dm_rdata_out`  output  32  extended load data; valid with `dm_ack_out`.
- `dm_err_out`  output  1  error flag; valid with `dm_ack_out`.
- `stall_out`  output  1  combinational; holds the PC while a request is pending.
- `mem_req_out`  output  1  memory request level.
- `mem_we_out`  output  1  write strobe.
- `mem_addr_out`  output  32  word address; bits [1:0] forced to 00.
- `mem_be_out`  output  4  byte enables; bit n selects byte lane n.
- `mem_wdata_out`  output  32  lane-replicated write data.
- `mem_ack_in`  input  1  memory completion, one cycle.
- `mem_rdata_in`  input  32  read data; valid with `mem_ack_in`.

## Operation
- States: IDLE, DATA, FETCH, RESP.
- IDLE:
  - If `dm_re_in` or `dm_we_in` is high, go to DATA.
  - Else if `if_req_in` is high, go to FETCH.
  - Data has fixed priority over fetch, because the data access belongs to the older instruction.
- Grant edge: the address, size, signed, write data and write flag are captured into registers. Requester inputs are ignored after capture.
- Both `dm_re_in` and `dm_we_in` high: treated as a write; the read is dropped.
- Little-endian lane mapping; lane = `addr[1:0]`.
  - Byte access: `mem_be_out` = 0001 shifted left by the lane; write data is the low byte replicated 4 times.
  - Halfword access: `mem_be_out` = 0011 shifted left by `addr[1]*2`; write data is the low halfword replicated 2 times.
  - Word access: `mem_be_out` = 1111.
  - Fetch: `mem_be_out` = 1111 and `mem_we_out` = 0.
- Loads: the selected lane is shifted down to bit 0, then extended per the captured signed flag.
- DATA or FETCH:
  - `mem_req_out` is held with stable address, data and enables until `mem_ack_in` is high.
  - On `mem_ack_in`, read data is registered and the state moves to RESP.
- RESP:
  - The matching ack output pulses for exactly one cycle.
  - New requests are not sampled. The requester must drop or change its request before the following edge.
  - Next state is IDLE.
- Timeout: a wait counter runs in DATA and FETCH.
  - When the counter reaches `TIMEOUT`, `mem_req_out` drops and the state moves to RESP.
  - `dm_err_out` = 1 for a data timeout. Read data is 0.
  - A fetch timeout returns `if_rdata_out` = 0.
- `stall_out` = ((`dm_re_in` | `dm_we_in`) & !`dm_ack_out`) | (`if_req_in` & !`if_ack_out`).

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-access: all outputs drop to 0 immediately and the in-flight access is abandoned. No ack is issued.
- Zero-wait access sequence:
  - Request sampled at edge 0.
  - `mem_req_out` high after edge 0.
  - `mem_ack_in` sampled at edge 1.
  - Ack output high after edge 1.
  - IDLE after edge 2.
  - Total: 3 cycles per access.
- N memory wait states add N cycles.
- Back-to-back: a fetch pending behind a data access is granted in the IDLE cycle following RESP.
- `mem_ack_in` is ignored outside DATA and FETCH.

## Configuration
- `MEM_PORT_ARB_ALIGN_CHECK_EN` defined:
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠00, issues no memory request.
  - The FSM goes DATA→RESP in one cycle with `dm_err_out`=1 and `dm_rdata_out`=0.
- Undefined: misaligned low address bits are truncated to the natural alignment, and the access proceeds normally.

## Test plan
- Fetch from 0x0000_0040, memory acks the first cycle with 0x2408_0005 -> `if_ack_out` one cycle, 3 cycles after request, `if_rdata_out`=0x2408_0005, `stall_out` low the cycle after.
- Signed byte load at 0x103, memory word 0x80FF_1234 -> `mem_be_out`=1000, `dm_rdata_out`=0xFFFF_FF80. Repeat unsigned -> 0x0000_0080.
- Halfword store at 0x202, data 0x0000_BEEF -> `mem_be_out`=1100, `mem_wdata_out`=0xBEEF_BEEF, `mem_we_out`=1, 2 memory wait states -> ack 5 cycles after request.
- Data and fetch requested in the same cycle -> data granted first; fetch `mem_req_out` begins the cycle after data RESP.
- `TIMEOUT`=4, memory never acks -> `mem_req_out` drops after 4 wait cycles, `dm_ack_out`=1 and `dm_err_out`=1. Then `rst_n_in` low mid-fetch -> all outputs 0 at once.
- Word load at 0x006 -> with the macro, error ack and no `mem_req_out`. Without the macro, address 0x004 is read.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store.
// Data has fixed priority over fetch, and the module does byte-lane steering and load extension.
// Optional feature: define MEM_PORT_ARB_ALIGN_CHECK_EN to reject misaligned halfword and word accesses.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_ack_out,
    output logic [31:0] if_rdata_out,
    input  logic        dm_re_in,
    input  logic        dm_we_in,
    input  logic [1:0]  dm_size_in,
    input  logic        dm_signed_in,
    input  logic [31:0] dm_addr_in,
    input  logic [31:0] dm_wdata_in,
    output logic        dm_ack_out,
    output logic [31:0] dm_rdata_out,
    output logic        dm_err_out,
    output logic        stall_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [3:0]  mem_be_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic             we_q;
    logic             mis_q;

    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic             mis_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      load_c;
    logic             timeout_c;

    // Lane enables, replicated store data and alignment error for the access being granted.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = dm_wdata_in;
        mis_c   = 1'b0;
        case (dm_size_in)
            2'b00: begin
                be_c    = 4'b0001 << dm_addr_in[1:0];
                wdata_c = {4{dm_wdata_in[7:0]}};
            end
            2'b01: begin
                be_c    = dm_addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{dm_wdata_in[15:0]}};
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
                mis_c   = dm_addr_in[0];
`endif
            end
            default: begin
`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
                mis_c   = |dm_addr_in[1:0];
`endif
            end
        endcase
    end

    // Shift the addressed lane down to bit 0 and extend it per the captured size and sign.
    always_comb begin
        byte_c = mem_rdata_in[{lane_q, 3'b000} +: 8];
        half_c = lane_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
        case (size_q)
            2'b00:   load_c = signed_q ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
            2'b01:   load_c = signed_q ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
            default: load_c = mem_rdata_in;
        endcase
    end

    // A zero TIMEOUT never matches, so the wait is unbounded.
    assign timeout_c = (32'(wait_cnt) + 32'd1) == TIMEOUT;

    // Stall while a requester has not yet seen its ack; forced low during reset.
    assign stall_out = rst_n_in & (((dm_re_in | dm_we_in) & ~dm_ack_out) | (if_req_in & ~if_ack_out));

    // Access sequencer: grant, hold the memory request, respond for one cycle, return to idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            lane_q        <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            we_q          <= 1'b0;
            mis_q         <= 1'b0;
            if_ack_out    <= 1'b0;
            if_rdata_out  <= '0;
            dm_ack_out    <= 1'b0;
            dm_rdata_out  <= '0;
            dm_err_out    <= 1'b0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_be_out    <= '0;
            mem_wdata_out <= '0;
        end else begin
            if_ack_out <= 1'b0;
            dm_ack_out <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (dm_re_in || dm_we_in) begin
                        state         <= DATA;
                        lane_q        <= dm_addr_in[1:0];
                        size_q        <= dm_size_in;
                        signed_q      <= dm_signed_in;
                        we_q          <= dm_we_in;
                        mis_q         <= mis_c;
                        mem_req_out   <= ~mis_c;
                        mem_we_out    <= dm_we_in & ~mis_c;
                        mem_addr_out  <= dm_addr_in & 32'hFFFF_FFFC;
                        mem_be_out    <= be_c;
                        mem_wdata_out <= dm_we_in ? wdata_c : '0;
                    end else if (if_req_in) begin
                        state         <= FETCH;
                        mem_req_out   <= 1'b1;
                        mem_we_out    <= 1'b0;
                        mem_addr_out  <= if_addr_in & 32'hFFFF_FFFC;
                        mem_be_out    <= 4'b1111;
                        mem_wdata_out <= '0;
                    end
                end
                DATA: begin
                    if (mis_q || mem_ack_in || timeout_c) begin
                        state         <= RESP;
                        dm_ack_out    <= 1'b1;
                        dm_err_out    <= mis_q | ~mem_ack_in;
                        dm_rdata_out  <= (mis_q || !mem_ack_in || we_q) ? '0 : load_c;
                        mem_req_out   <= 1'b0;
                        mem_we_out    <= 1'b0;
                        mem_addr_out  <= '0;
                        mem_be_out    <= '0;
                        mem_wdata_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FETCH: begin
                    if (mem_ack_in || timeout_c) begin
                        state         <= RESP;
                        if_ack_out    <= 1'b1;
                        if_rdata_out  <= mem_ack_in ? mem_rdata_in : '0;
                        mem_req_out   <= 1'b0;
                        mem_addr_out  <= '0;
                        mem_be_out    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    if_rdata_out <= '0;
                    dm_rdata_out <= '0;
                    dm_err_out   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
